pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- PLL_RST_CYCLES, 16: pll_resetb low time per PLL reset pulse.
- LOCK_TIMEOUT, 4096: cycles to wait for lock before retry.
- STABLE_CYCLES, 256: cycles lock must hold before release starts.
- NUM_STAGES, 3: number of staged domain resets.
- STAGE_GAP, 8: cycles between successive stage releases.
REQ-002 Ports SHALL be (name, direction, width, meaning), one per line:
- clock, input, 1: free-running reference clock (PLL input clock, not PLL output).
- reset_n, input, 1: asynchronous, active-low reset.
- locked, input, 1: PLL lock, asynchronous to clock.
- sw_reset_req, input, 1: single-cycle request to re-reset the domains.
- pll_resetb, output, 1: PLL RESETB, active-low.
- rst_n_out, output, NUM_STAGES: per-stage domain resets, active-low; bit 0 released first.
- ready, output, 1: all stages released.
- lock_timeout, output, 1: sticky flag, set on any lock timeout.
- retry_count, output, 4: PLL reset retries, saturating.
REQ-003 The block SHALL use one clock (clock); reset_n SHALL be asynchronous, active-low.

Function
REQ-004 locked SHALL pass through a 2-flop synchronizer (locked_s); all decisions use locked_s only.
REQ-005 FSM states SHALL be PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN; one shared cycle counter cleared on every state entry.
REQ-006 PLL_RST: pll_resetb=0 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK.
REQ-007 WAIT_LOCK: pll_resetb=1. locked_s=1 -> STABLE. Otherwise, when counter reaches LOCK_TIMEOUT-1 -> PLL_RST, set lock_timeout, increment retry_count (saturates at 15).
REQ-008 STABLE: locked_s=0 -> WAIT_LOCK with timeout restarted. Counter reaches STABLE_CYCLES-1 with locked_s=1 throughout -> RELEASE.
REQ-009 RELEASE: rst_n_out[0] rises on the first RELEASE cycle; rst_n_out[k] rises k*STAGE_GAP cycles later. Once bit NUM_STAGES-1 is released, the FSM enters RUN and ready=1 in the same cycle as that release.
REQ-010 RUN: hold all rst_n_out=1 and ready=1.
REQ-011 locked_s=0 in RELEASE or RUN: at the next edge, all rst_n_out=0, ready=0, FSM goes to WAIT_LOCK. The PLL is not reset.
REQ-012 sw_reset_req=1 in RELEASE or RUN: at the next edge, all rst_n_out=0, ready=0, FSM goes to STABLE. sw_reset_req is ignored in all other states.
REQ-013 Lock loss and sw_reset_req in the same cycle: lock loss wins (REQ-011).
REQ-014 Stage resets SHALL only be released in RELEASE, in index order; assertion SHALL be simultaneous for all bits.
REQ-015 All outputs SHALL be registered, glitch-free.
REQ-016 Counter width SHALL hold the maximum of all cycle parameters; no wrap occurs inside any state.

Reset
REQ-017 reset_n=0 SHALL immediately force: state PLL_RST, counter=0, pll_resetb=0, rst_n_out=0, ready=0, lock_timeout=0, retry_count=0, synchronizer flops=0.
REQ-018 reset_n asserted mid-operation SHALL abort any state. After deassertion the sequence restarts from PLL_RST with a full PLL_RST_CYCLES pulse.

Verification
REQ-019 The bench SHALL cover these directed scenarios (defaults):
- Nominal: reset release, locked=1 at cycle 20 -> pll_resetb high for cycles 16+; RELEASE after 2 sync + 256 stable cycles; rst_n_out bits rise at +0/+8/+16; ready with bit 2.
- Timeout: locked held 0 -> after 4096 WAIT_LOCK cycles, pll_resetb low for 16; lock_timeout=1; retry_count=1. 20 timeouts -> retry_count=15.
- Glitch in STABLE: locked drops for 3 cycles at stable count 100 -> back to WAIT_LOCK; full 256-cycle hold restarts; no rst_n_out release before it completes.
- Lock loss in RUN: locked=0 -> one edge after locked_s falls, rst_n_out=3'b000 and ready=0; pll_resetb stays 1; relock repeats the full STABLE+RELEASE sequence.
- sw_reset_req in RUN, and together with lock loss -> STABLE (rst_n_out=0, 256-cycle hold) and WAIT_LOCK respectively.
- reset_n pulsed during RELEASE after bit 0 released -> all outputs at reset values asynchronously; new 16-cycle PLL reset follows.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer.
// Pulses the PLL reset and waits for lock, retrying on timeout. Once lock has
// held for STABLE_CYCLES it releases the domain resets one stage at a time,
// STAGE_GAP cycles apart. Losing lock drops every domain reset and goes back
// to waiting for lock without touching the PLL. A software request re-runs
// the stable hold and the staged release.
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 4096,
   parameter int STABLE_CYCLES  = 256,
   parameter int NUM_STAGES     = 3,
   parameter int STAGE_GAP      = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  locked,
   input  logic                  sw_reset_req,
   output logic                  pll_resetb,
   output logic [NUM_STAGES-1:0] rst_n_out,
   output logic                  ready,
   output logic                  lock_timeout,
   output logic [3:0]            retry_count
);

   // The counter must reach the largest terminal count of any state without
   // wrapping. That includes the offset of the last stage release.
   localparam int REL_SPAN = (NUM_STAGES - 1) * STAGE_GAP + 1;
   localparam int MAX_AB   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CD   = (STABLE_CYCLES > REL_SPAN) ? STABLE_CYCLES : REL_SPAN;
   localparam int CNT_MAX  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic                    lock_meta;
   logic                    locked_s;
   logic [NUM_STAGES-1:0]   stage_hit;
   logic                    last_hit;

   // Bit 0 is released when RELEASE is entered. Every later stage k is
   // released on the edge that ends RELEASE cycle k*STAGE_GAP-1.
   assign stage_hit[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_stage_hit
         assign stage_hit[gi] = (cnt == CNT_W'(gi * STAGE_GAP - 1));
      end
   endgenerate

   assign last_hit = stage_hit[NUM_STAGES-1];

   // Lock synchronizer, sequencing FSM and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta    <= 1'b0;
         locked_s     <= 1'b0;
         state        <= PLL_RST;
         cnt          <= '0;
         pll_resetb   <= 1'b0;
         rst_n_out    <= '0;
         ready        <= 1'b0;
         lock_timeout <= 1'b0;
         retry_count  <= 4'd0;
      end else begin
         lock_meta <= locked;
         locked_s  <= lock_meta;

         case (state)
            PLL_RST: begin
               if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
                  state      <= WAIT_LOCK;
                  cnt        <= '0;
                  pll_resetb <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            WAIT_LOCK: begin
               if (locked_s) begin
                  state <= STABLE;
                  cnt   <= '0;
               end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                  state        <= PLL_RST;
                  cnt          <= '0;
                  pll_resetb   <= 1'b0;
                  lock_timeout <= 1'b1;
                  if (retry_count != 4'hF) begin
                     retry_count <= retry_count + 4'd1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            STABLE: begin
               if (!locked_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                  cnt       <= '0;
                  rst_n_out <= NUM_STAGES'(1);
                  // A single stage is fully released on entry, so go straight to RUN.
                  if (NUM_STAGES == 1) begin
                     state <= RUN;
                     ready <= 1'b1;
                  end else begin
                     state <= RELEASE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            RELEASE, RUN: begin
               // Lock loss takes priority over a software request.
               if (!locked_s) begin
                  state     <= WAIT_LOCK;
                  cnt       <= '0;
                  rst_n_out <= '0;
                  ready     <= 1'b0;
               end else if (sw_reset_req) begin
                  state     <= STABLE;
                  cnt       <= '0;
                  rst_n_out <= '0;
                  ready     <= 1'b0;
               end else if (state == RELEASE) begin
                  rst_n_out <= rst_n_out | stage_hit;
                  if (last_hit) begin
                     state <= RUN;
                     cnt   <= '0;
                     ready <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end

            default: begin
               state      <= PLL_RST;
               cnt        <= '0;
               pll_resetb <= 1'b0;
               rst_n_out  <= '0;
               ready      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer.
// A behavioural model tracks the sequencer phase and the time spent in it.
// Every cycle the DUT outputs are compared against that model. Directed
// scenarios are followed by a randomized lock / request / reset phase.
// LOCK_TIMEOUT is shortened so that the 20-retry saturation run stays short.
module tb_pll_reset_sequencer;

   localparam int P_RST = 16;
   localparam int P_TO  = 512;
   localparam int P_ST  = 256;
   localparam int P_N   = 3;
   localparam int P_GAP = 8;

   localparam int PH_PLL    = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_STABLE = 2;
   localparam int PH_REL    = 3;
   localparam int PH_RUN    = 4;

   logic           clock = 1'b0;
   logic           reset_n;
   logic           locked;
   logic           sw_reset_req;
   logic           pll_resetb;
   logic [P_N-1:0] rst_n_out;
   logic           ready;
   logic           lock_timeout;
   logic [3:0]     retry_count;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state.
   int m_ph;
   int m_t;
   bit m_s1;
   bit m_s2;
   bit m_to;
   int m_retry;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES(P_RST),
      .LOCK_TIMEOUT  (P_TO),
      .STABLE_CYCLES (P_ST),
      .NUM_STAGES    (P_N),
      .STAGE_GAP     (P_GAP)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .locked      (locked),
      .sw_reset_req(sw_reset_req),
      .pll_resetb  (pll_resetb),
      .rst_n_out   (rst_n_out),
      .ready       (ready),
      .lock_timeout(lock_timeout),
      .retry_count (retry_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_ph    = PH_PLL;
      m_t     = 0;
      m_s1    = 1'b0;
      m_s2    = 1'b0;
      m_to    = 1'b0;
      m_retry = 0;
   endfunction

   function automatic logic [P_N-1:0] exp_rst();
      logic [P_N-1:0] v;
      v = '0;
      for (int k = 0; k < P_N; k++) begin
         if (m_ph == PH_RUN || (m_ph == PH_REL && m_t >= k * P_GAP)) v[k] = 1'b1;
      end
      return v;
   endfunction

   // One clock edge of the reference model, using the inputs held at that edge.
   function automatic void model_step();
      bit ls;
      if (!reset_n) begin
         model_reset();
         return;
      end
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = locked;
      case (m_ph)
         PH_PLL: begin
            m_t++;
            if (m_t == P_RST) begin m_ph = PH_WAIT; m_t = 0; end
         end
         PH_WAIT: begin
            if (ls) begin
               m_ph = PH_STABLE; m_t = 0;
            end else begin
               m_t++;
               if (m_t == P_TO) begin
                  m_ph = PH_PLL; m_t = 0; m_to = 1'b1;
                  if (m_retry < 15) m_retry++;
               end
            end
         end
         PH_STABLE: begin
            if (!ls) begin
               m_ph = PH_WAIT; m_t = 0;
            end else begin
               m_t++;
               if (m_t == P_ST) begin
                  m_ph = (P_N == 1) ? PH_RUN : PH_REL; m_t = 0;
               end
            end
         end
         default: begin
            if (!ls) begin
               m_ph = PH_WAIT; m_t = 0;
            end else if (sw_reset_req) begin
               m_ph = PH_STABLE; m_t = 0;
            end else if (m_ph == PH_REL) begin
               m_t++;
               if (m_t >= (P_N - 1) * P_GAP) m_ph = PH_RUN;
            end
         end
      endcase
   endfunction

   task automatic cycle();
      @(posedge clock);
      model_step();
      @(negedge clock);
      check("pll_resetb", 32'(pll_resetb), 32'(m_ph != PH_PLL));
      check("rst_n_out", 32'(rst_n_out), 32'(exp_rst()));
      check("ready", 32'(ready), 32'(m_ph == PH_RUN));
      check("lock_timeout", 32'(lock_timeout), 32'(m_to));
      check("retry_count", 32'(retry_count), 32'(m_retry));
   endtask

   task automatic run_until_ph(input string tag, input int ph, input int budget);
      int n;
      n = 0;
      while (m_ph != ph && n < budget) begin
         cycle();
         n++;
      end
      check(tag, 32'(m_ph == ph), 32'd1);
   endtask

   task automatic run_until_at(input string tag, input int ph, input int t, input int budget);
      int n;
      n = 0;
      while (!(m_ph == ph && m_t == t) && n < budget) begin
         cycle();
         n++;
      end
      check(tag, 32'(m_ph == ph && m_t == t), 32'd1);
   endtask

   initial begin
      int edges;
      int pll_edge;
      int rise[P_N];

      reset_n      = 1'b0;
      locked       = 1'b0;
      sw_reset_req = 1'b0;
      model_reset();
      repeat (3) cycle();

      // Nominal bring-up: lock asserted after cycle 20.
      reset_n  = 1'b1;
      edges    = 0;
      pll_edge = -1;
      for (int k = 0; k < P_N; k++) rise[k] = -1;
      while (!ready && edges < 2000) begin
         if (edges == 20) locked = 1'b1;
         cycle();
         edges++;
         if (pll_resetb && pll_edge < 0) pll_edge = edges;
         for (int k = 0; k < P_N; k++) begin
            if (rst_n_out[k] && rise[k] < 0) rise[k] = edges;
         end
      end
      check("nominal_pllrb_edge", 32'(pll_edge), 32'(P_RST));
      for (int k = 0; k < P_N; k++) begin
         check($sformatf("nominal_stage%0d_edge", k), 32'(rise[k]), 32'(20 + 2 + 1 + P_ST + k * P_GAP));
      end
      check("nominal_ready_edge", 32'(edges), 32'(20 + 2 + 1 + P_ST + (P_N - 1) * P_GAP));
      repeat (10) cycle();

      // Lock loss in RUN: outputs drop one edge after locked_s falls.
      locked = 1'b0;
      repeat (2) cycle();
      check("lockloss_ready_before", 32'(ready), 32'd1);
      cycle();
      check("lockloss_rst", 32'(rst_n_out), 32'd0);
      check("lockloss_ready", 32'(ready), 32'd0);
      check("lockloss_pllrb", 32'(pll_resetb), 32'd1);
      repeat (5) cycle();
      locked = 1'b1;
      run_until_ph("relock_run", PH_RUN, 2000);
      repeat (5) cycle();

      // Software request in RUN.
      sw_reset_req = 1'b1;
      cycle();
      sw_reset_req = 1'b0;
      check("sw_rst", 32'(rst_n_out), 32'd0);
      check("sw_ready", 32'(ready), 32'd0);
      run_until_ph("sw_run", PH_RUN, 2000);
      repeat (5) cycle();

      // Software request coinciding with lock loss: lock loss wins.
      locked = 1'b0;
      repeat (2) cycle();
      sw_reset_req = 1'b1;
      cycle();
      sw_reset_req = 1'b0;
      check("sw_lockloss_rst", 32'(rst_n_out), 32'd0);
      repeat (600) cycle();
      locked = 1'b1;
      run_until_ph("sw_lockloss_run", PH_RUN, 3000);

      // Short lock glitch at stable count 100.
      sw_reset_req = 1'b1;
      cycle();
      sw_reset_req = 1'b0;
      run_until_at("glitch_at_100", PH_STABLE, 100, 500);
      locked = 1'b0;
      repeat (3) cycle();
      locked = 1'b1;
      run_until_ph("glitch_run", PH_RUN, 2000);

      // Asynchronous reset after stage 0 is released.
      sw_reset_req = 1'b1;
      cycle();
      sw_reset_req = 1'b0;
      run_until_at("rel_at_3", PH_REL, 3, 500);
      check("rel_stage0", 32'(rst_n_out[0]), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check("async_pllrb", 32'(pll_resetb), 32'd0);
      check("async_rst", 32'(rst_n_out), 32'd0);
      check("async_ready", 32'(ready), 32'd0);
      check("async_timeout", 32'(lock_timeout), 32'd0);
      check("async_retry", 32'(retry_count), 32'd0);
      repeat (2) cycle();
      reset_n = 1'b1;
      run_until_ph("post_reset_run", PH_RUN, 2000);

      // Lock timeouts: first retry, then saturation after 20.
      locked = 1'b0;
      run_until_ph("timeout_first", PH_PLL, 2000);
      check("timeout_flag", 32'(lock_timeout), 32'd1);
      check("timeout_retry1", 32'(retry_count), 32'd1);
      check("timeout_pllrb", 32'(pll_resetb), 32'd0);
      for (int i = 1; i < 20; i++) begin
         run_until_ph("timeout_wait", PH_WAIT, 100);
         run_until_ph("timeout_next", PH_PLL, 2000);
      end
      check("timeout_retry_sat", 32'(retry_count), 32'd15);
      locked = 1'b1;
      run_until_ph("timeout_recover", PH_RUN, 2000);

      // Randomized lock behaviour, software requests and occasional resets.
      for (int i = 0; i < 5000; i++) begin
         if (locked) begin
            if ($urandom_range(399) == 0) locked = 1'b0;
         end else begin
            if ($urandom_range(19) == 0) locked = 1'b1;
         end
         sw_reset_req = ($urandom_range(99) == 0);
         if (!reset_n) reset_n = 1'b1;
         else if ($urandom_range(1999) == 0) reset_n = 1'b0;
         cycle();
      end
      sw_reset_req = 1'b0;
      reset_n      = 1'b1;
      repeat (3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
